conv_lane_scheduler: RTL and testbench

- Parametrised successor to the conv FSM controller.
- Walks every output position (row, col, filter) of one conv layer and dispatches one job per output pixel to a free multiplier lane from a pool of NMULT lanes.
- Tracks lane occupancy, honours lanes reserved externally, and retires lanes on completion pulses.
- Sits between the layer sequencer (start/en) and the MAC lane array.

---
 rtl/conv_lane_scheduler_if.sv | 39 +++
 rtl/conv_lane_scheduler.sv | 142 ++++++++++++++
 tb/tb_conv_lane_scheduler.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_lane_scheduler_if.sv
// Bundle between the layer sequencer / MAC lane array and conv_lane_scheduler.
// Widths are derived here from the same layer parameters the scheduler uses.
interface conv_lane_scheduler_if #(
  parameter int N     = 32,
  parameter int P     = 1,
  parameter int NF    = 3,
  parameter int NMULT = 64
);
  localparam int LW = $clog2(NMULT);
  localparam int CW = $clog2(N + 2*P) + 2;
  localparam int FW = $clog2(NF) + 1;

  logic                 start;
  logic                 en;
  logic [NMULT-1:0]     lane_busy_ext;
  logic [NMULT-1:0]     lane_done;
  logic                 job_valid;
  logic [LW-1:0]        job_lane;
  logic [CW-1:0]        job_orow;
  logic [CW-1:0]        job_ocol;
  logic [FW-1:0]        job_filt;
  logic signed [CW-1:0] job_irow;
  logic signed [CW-1:0] job_icol;
  logic [NMULT-1:0]     lane_alloc;
  logic [LW:0]          free_cnt;
  logic                 busy;
  logic                 done;

  modport master (
    output start, en, lane_busy_ext, lane_done,
    input  job_valid, job_lane, job_orow, job_ocol, job_filt, job_irow, job_icol,
    input  lane_alloc, free_cnt, busy, done
  );
  modport slave (
    input  start, en, lane_busy_ext, lane_done,
    output job_valid, job_lane, job_orow, job_ocol, job_filt, job_irow, job_icol,
    output lane_alloc, free_cnt, busy, done
  );
endinterface

// File: rtl/conv_lane_scheduler.sv
// Conv layer scheduler: walks (orow, ocol, filt) of one layer and dispatches one
// job per output pixel to the lowest-indexed free multiplier lane.
module conv_lane_slot (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic done,
  output logic alloc
);
  // issue only ever targets an unowned lane, so a done on that lane is moot
  always_ff @(posedge clk)
    if (rst) alloc <= 1'b0;
    else     alloc <= (alloc & ~done) | issue;
endmodule

module conv_lane_scheduler #(
  parameter int N     = 32,
  parameter int F     = 3,
  parameter int K     = 3,
  parameter int NF    = 3,
  parameter int P     = 1,
  parameter int S     = 1,
  parameter int NMULT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_lane_scheduler_if.slave  bus
);
  // K only sizes the lane datapath downstream; it does not change the walk
  localparam int OUT = (N - F + 2*P) / S + 1 + 0*K;
  localparam int LW  = $clog2(NMULT);
  localparam int CW  = $clog2(N + 2*P) + 2;
  localparam int FW  = $clog2(NF) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    orow, ocol;
  logic [FW-1:0]    filt;
  logic [NMULT-1:0] lane_alloc, lane_free, issue_oh;
  logic [LW-1:0]    sel;
  logic [LW:0]      free_cnt;
  logic             any_free, issue, last_tuple;

  assign lane_free = ~(lane_alloc | bus.lane_busy_ext);

  // lowest free index wins
  always_comb begin
    sel      = '0;
    any_free = 1'b0;
    for (int i = NMULT-1; i >= 0; i--)
      if (lane_free[i]) begin
        sel      = LW'(i);
        any_free = 1'b1;
      end
  end

  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NMULT; i++)
      free_cnt = free_cnt + (LW+1)'(lane_free[i]);
  end

  assign issue      = (state == RUN) && bus.en && any_free;
  assign last_tuple = (orow == CW'(OUT-1)) && (ocol == CW'(OUT-1)) && (filt == FW'(NF-1));

  always_comb begin
    issue_oh = '0;
    if (issue) issue_oh[sel] = 1'b1;
  end

  for (genvar i = 0; i < NMULT; i++) begin : g_lane
    conv_lane_slot u_slot (
      .clk   (clk),
      .rst   (rst),
      .issue (issue_oh[i]),
      .done  (bus.lane_done[i]),
      .alloc (lane_alloc[i])
    );
  end

  assign bus.lane_alloc = lane_alloc;
  assign bus.free_cnt   = free_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      orow          <= '0;
      ocol          <= '0;
      filt          <= '0;
      bus.job_valid <= 1'b0;
      bus.job_lane  <= '0;
      bus.job_orow  <= '0;
      bus.job_ocol  <= '0;
      bus.job_filt  <= '0;
      bus.job_irow  <= '0;
      bus.job_icol  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.job_valid <= 1'b0;
      bus.done      <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state    <= RUN;
          orow     <= '0;
          ocol     <= '0;
          filt     <= '0;
          bus.busy <= 1'b1;
        end
        RUN: if (issue) begin
          bus.job_valid <= 1'b1;
          bus.job_lane  <= sel;
          bus.job_orow  <= orow;
          bus.job_ocol  <= ocol;
          bus.job_filt  <= filt;
          // window origin in two's complement; negative means padding
          bus.job_irow  <= CW'(int'(orow) * S - P);
          bus.job_icol  <= CW'(int'(ocol) * S - P);
          if (filt == FW'(NF-1)) begin
            filt <= '0;
            if (ocol == CW'(OUT-1)) begin
              ocol <= '0;
              orow <= orow + CW'(1);
            end else begin
              ocol <= ocol + CW'(1);
            end
          end else begin
            filt <= filt + FW'(1);
          end
          if (last_tuple) state <= DRAIN;
        end
        DRAIN: if (lane_alloc == '0) begin
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_lane_scheduler.sv
// Bench for conv_lane_scheduler: default layer, a 4-lane tiny layer checked against
// a job-index reference model, and a strided/padded 4-lane layer.
module tb_conv_lane_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  int checks = 0, failures = 0;

  localparam int A_N = 32, A_F = 3, A_K = 3, A_NF = 3, A_P = 1, A_S = 1, A_M = 64;
  localparam int A_OUT = (A_N - A_F + 2*A_P) / A_S + 1;
  localparam int A_JOBS = A_OUT * A_OUT * A_NF;
  localparam int B_N = 4, B_F = 3, B_NF = 2, B_P = 0, B_S = 1, B_M = 4;
  localparam int B_OUT = (B_N - B_F + 2*B_P) / B_S + 1;
  localparam int B_JOBS = B_OUT * B_OUT * B_NF;
  localparam int C_N = 8, C_F = 3, C_NF = 2, C_P = 1, C_S = 2, C_M = 4;
  localparam int C_OUT = (C_N - C_F + 2*C_P) / C_S + 1;
  localparam int C_JOBS = C_OUT * C_OUT * C_NF;

  conv_lane_scheduler_if #(.N(A_N), .P(A_P), .NF(A_NF), .NMULT(A_M)) aif();
  conv_lane_scheduler_if #(.N(B_N), .P(B_P), .NF(B_NF), .NMULT(B_M)) bif();
  conv_lane_scheduler_if #(.N(C_N), .P(C_P), .NF(C_NF), .NMULT(C_M)) cif();

  conv_lane_scheduler #(.N(A_N), .F(A_F), .K(A_K), .NF(A_NF), .P(A_P), .S(A_S), .NMULT(A_M))
    u_a (.clk(clk), .rst(rst_a), .bus(aif));
  conv_lane_scheduler #(.N(B_N), .F(B_F), .K(3), .NF(B_NF), .P(B_P), .S(B_S), .NMULT(B_M))
    u_b (.clk(clk), .rst(rst_b), .bus(bif));
  conv_lane_scheduler #(.N(C_N), .F(C_F), .K(3), .NF(C_NF), .P(C_P), .S(C_S), .NMULT(C_M))
    u_c (.clk(clk), .rst(rst_c), .bus(cif));

  logic [19:0] b_job;
  assign b_job = {bif.job_lane, bif.job_orow, bif.job_ocol, bif.job_filt, bif.job_irow, bif.job_icol};
  logic [40:0] a_job;
  assign a_job = {aif.job_lane, aif.job_orow, aif.job_ocol, aif.job_filt, aif.job_irow, aif.job_icol};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---- reference model for the tiny layer: job index k + owned-lane set ----
  int         m_phase;   // 0 idle, 1 issuing, 2 waiting for lanes, 3 finished
  int         m_k;
  logic [3:0] m_alloc;
  logic       m_valid, m_done;
  logic [19:0] m_job;

  function automatic logic [19:0] b_tuple(input int k, input int lane);
    int f, oc, orr;
    f   = k % B_NF;
    oc  = (k / B_NF) % B_OUT;
    orr = k / (B_NF * B_OUT);
    return {2'(lane), 4'(orr), 4'(oc), 2'(f), 4'(orr*B_S - B_P), 4'(oc*B_S - B_P)};
  endfunction

  task automatic b_step(input logic st, input logic en_i, input logic [3:0] bx,
                        input logic [3:0] ld, input logic rs);
    logic [3:0] iss, fr;
    int lane;
    bif.start = st; bif.en = en_i; bif.lane_busy_ext = bx; bif.lane_done = ld; rst_b = rs;
    m_valid = 1'b0; m_done = 1'b0; iss = '0;
    if (rs) begin
      m_phase = 0; m_alloc = '0; m_job = '0;
    end else begin
      case (m_phase)
        0: if (st) begin m_phase = 1; m_k = 0; end
        1: begin
          fr = ~m_alloc & ~bx;
          lane = -1;
          for (int l = 0; l < 4; l++) if (fr[l] && lane < 0) lane = l;
          if (en_i && lane >= 0) begin
            iss[lane] = 1'b1; m_valid = 1'b1; m_job = b_tuple(m_k, lane); m_k++;
            if (m_k == B_JOBS) m_phase = 2;
          end
        end
        2: if (m_alloc == '0) begin m_phase = 3; m_done = 1'b1; end
        default: m_phase = 0;
      endcase
      m_alloc = (m_alloc & ~ld) | iss;
    end
    @(posedge clk); #1;
    chk("b_valid", bif.job_valid, m_valid);
    chk("b_job",   b_job, m_job);
    chk("b_alloc", bif.lane_alloc, m_alloc);
    chk("b_free",  bif.free_cnt, $countones(~m_alloc & ~bx));
    chk("b_busy",  bif.busy, (m_phase == 1 || m_phase == 2));
    chk("b_done",  bif.done, m_done);
  endtask

  typedef struct {
    logic st; logic [3:0] ld; logic vld; int lane; int k;
    logic [3:0] alloc; int free; logic busy; logic done;
  } vec_t;
  vec_t tv [15];

  int cnt, ord, dcnt, early, hold, last_ld, done_at, first_cyc;
  int e_f, e_c, e_r;
  int a_due [A_M];
  int c_due [4];
  int t_due [4];
  logic [A_M-1:0] a_ld;
  logic [3:0] ld4, alloc_at_done;
  logic seen;

  initial begin
    aif.start = 0; aif.en = 1; aif.lane_busy_ext = '0; aif.lane_done = '0;
    bif.start = 0; bif.en = 1; bif.lane_busy_ext = '0; bif.lane_done = '0;
    cif.start = 0; cif.en = 1; cif.lane_busy_ext = '0; cif.lane_done = '0;

    // ---------------- default layer ----------------
    repeat (2) @(posedge clk); #1;
    chk("a_rst_status", {aif.job_valid, aif.busy, aif.done}, 0);
    chk("a_rst_alloc", aif.lane_alloc, 0);
    chk("a_rst_job", a_job, 0);
    rst_a = 0;
    aif.start = 1; @(posedge clk); #1; aif.start = 0;
    cnt = 0; ord = 0; dcnt = 0; early = 0; first_cyc = -1;
    for (int l = 0; l < A_M; l++) a_due[l] = 0;
    for (int cyc = 0; cyc < 4000 && !(dcnt > 0 && !aif.busy); cyc++) begin
      @(posedge clk); #1;
      if (aif.job_valid) begin
        if (cnt == 0) begin
          first_cyc = cyc;
          chk("a_first_job", a_job, {6'd0, 8'd0, 8'd0, 3'd0, 8'hFF, 8'hFF});
        end
        e_f = cnt % A_NF; e_c = (cnt / A_NF) % A_OUT; e_r = cnt / (A_NF * A_OUT);
        if (int'(aif.job_orow) != e_r || int'(aif.job_ocol) != e_c || int'(aif.job_filt) != e_f ||
            int'(aif.job_irow) != e_r*A_S - A_P || int'(aif.job_icol) != e_c*A_S - A_P) ord++;
        a_due[aif.job_lane] = 3;
        cnt++;
      end
      if (aif.done) begin dcnt++; if (cnt != A_JOBS) early++; end
      a_ld = '0;
      for (int l = 0; l < A_M; l++)
        if (a_due[l] > 0) begin a_due[l]--; if (a_due[l] == 0) a_ld[l] = 1'b1; end
      aif.lane_done = a_ld;
    end
    repeat (3) begin @(posedge clk); #1; if (aif.done) dcnt++; end
    chk("a_latency", first_cyc, 0);
    chk("a_job_count", cnt, A_JOBS);
    chk("a_order", ord, 0);
    chk("a_done_pulses", dcnt, 1);
    chk("a_done_early", early, 0);
    chk("a_busy_after", aif.busy, 0);
    chk("a_alloc_after", aif.lane_alloc, 0);
    rst_a = 1;

    // ---------------- tiny layer: table of cycles ----------------
    tv[0]  = '{1'b1, 4'b0000, 1'b0, 0, 0, 4'b0000, 4, 1'b1, 1'b0};
    tv[1]  = '{1'b0, 4'b0000, 1'b1, 0, 0, 4'b0001, 3, 1'b1, 1'b0};
    tv[2]  = '{1'b0, 4'b0000, 1'b1, 1, 1, 4'b0011, 2, 1'b1, 1'b0};
    tv[3]  = '{1'b0, 4'b0000, 1'b1, 2, 2, 4'b0111, 1, 1'b1, 1'b0};
    tv[4]  = '{1'b0, 4'b0000, 1'b1, 3, 3, 4'b1111, 0, 1'b1, 1'b0};
    tv[5]  = '{1'b0, 4'b0000, 1'b0, 3, 3, 4'b1111, 0, 1'b1, 1'b0};
    tv[6]  = '{1'b0, 4'b0100, 1'b0, 3, 3, 4'b1011, 1, 1'b1, 1'b0};
    tv[7]  = '{1'b0, 4'b0000, 1'b1, 2, 4, 4'b1111, 0, 1'b1, 1'b0};
    tv[8]  = '{1'b0, 4'b1111, 1'b0, 2, 4, 4'b0000, 4, 1'b1, 1'b0};
    tv[9]  = '{1'b0, 4'b0000, 1'b1, 0, 5, 4'b0001, 3, 1'b1, 1'b0};
    tv[10] = '{1'b0, 4'b0000, 1'b1, 1, 6, 4'b0011, 2, 1'b1, 1'b0};
    tv[11] = '{1'b0, 4'b0000, 1'b1, 2, 7, 4'b0111, 1, 1'b1, 1'b0};
    tv[12] = '{1'b0, 4'b0111, 1'b0, 2, 7, 4'b0000, 4, 1'b1, 1'b0};
    tv[13] = '{1'b0, 4'b0000, 1'b0, 2, 7, 4'b0000, 4, 1'b0, 1'b1};
    tv[14] = '{1'b0, 4'b0000, 1'b0, 2, 7, 4'b0000, 4, 1'b0, 1'b0};
    b_step(0, 1, 4'b0, 4'b0, 1);
    for (int i = 0; i < 15; i++) begin
      b_step(tv[i].st, 1, 4'b0, tv[i].ld, 0);
      chk("t2_valid", bif.job_valid, tv[i].vld);
      chk("t2_job",   b_job, b_tuple(tv[i].k, tv[i].lane));
      chk("t2_alloc", bif.lane_alloc, tv[i].alloc);
      chk("t2_free",  bif.free_cnt, tv[i].free);
      chk("t2_flags", {bif.busy, bif.done}, {tv[i].busy, tv[i].done});
    end

    // ---------------- external reservation of lanes 0 and 2 ----------------
    b_step(0, 1, 4'b0, 4'b0, 1);
    b_step(1, 1, 4'b0101, 4'b0, 0);
    for (int l = 0; l < 4; l++) t_due[l] = 0;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      ld4 = '0;
      for (int l = 0; l < 4; l++)
        if (t_due[l] > 0) begin t_due[l]--; if (t_due[l] == 0) ld4[l] = 1'b1; end
      b_step(0, 1, 4'b0101, ld4, 0);
      if (bif.job_valid) begin
        chk("t3_lane_odd", bif.job_lane[0], 1);
        t_due[bif.job_lane] = 2;
      end
      chk("t3_alloc_mask", bif.lane_alloc & 4'b0101, 0);
      chk("t3_free_max", bif.free_cnt <= 2, 1);
      seen = bif.done;
    end
    chk("t3_done_seen", seen, 1);

    // ---------------- reset mid-layer, stray done, restart ----------------
    b_step(0, 1, 4'b0, 4'b0, 1);
    b_step(1, 1, 4'b0, 4'b0, 0);
    b_step(0, 1, 4'b0, 4'b0, 0);
    b_step(0, 1, 4'b0, 4'b0, 0);
    b_step(1, 1, 4'b0, 4'b0, 0);
    chk("t6_start_ignored", b_job, b_tuple(2, 2));
    chk("t6_three_lanes", bif.lane_alloc, 4'b0111);
    b_step(0, 1, 4'b0, 4'b0, 1);
    chk("t6_rst_alloc", bif.lane_alloc, 0);
    chk("t6_rst_flags", {bif.job_valid, bif.busy, bif.done}, 0);
    b_step(0, 1, 4'b0, 4'b1111, 0);
    chk("t6_stray_alloc", bif.lane_alloc, 0);
    chk("t6_stray_done", bif.done, 0);
    b_step(1, 1, 4'b0, 4'b0, 0);
    b_step(0, 1, 4'b0, 4'b0, 0);
    chk("t6_restart_valid", bif.job_valid, 1);
    chk("t6_restart_job", b_job, b_tuple(0, 0));

    // ---------------- randomized run against the model ----------------
    b_step(0, 1, 4'b0, 4'b0, 1);
    for (int c = 0; c < 800; c++)
      b_step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
             4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom),
             $urandom_range(0, 63) == 0);
    rst_b = 1;

    // ---------------- strided, padded layer with an issue stall ----------------
    @(posedge clk); #1; rst_c = 0;
    cif.start = 1; @(posedge clk); #1; cif.start = 0;
    cnt = 0; ord = 0; hold = 0; last_ld = -1; done_at = -1; alloc_at_done = '1;
    for (int l = 0; l < 4; l++) c_due[l] = 0;
    for (int cyc = 0; cyc < 400 && done_at < 0; cyc++) begin
      @(posedge clk); #1;
      if (hold > 0) begin
        chk("t4_stall_valid", cif.job_valid, 0);
        hold--;
        if (hold == 0) begin chk("t4_drained", cif.lane_alloc, 0); cif.en = 1; end
      end
      if (cif.job_valid) begin
        e_f = cnt % C_NF; e_c = (cnt / C_NF) % C_OUT; e_r = cnt / (C_NF * C_OUT);
        if (int'(cif.job_orow) != e_r || int'(cif.job_ocol) != e_c || int'(cif.job_filt) != e_f ||
            int'(cif.job_irow) != e_r*C_S - C_P || int'(cif.job_icol) != e_c*C_S - C_P) ord++;
        if (cnt == 10)
          chk("t4_resume_tuple", {cif.job_orow, cif.job_ocol, cif.job_filt}, {6'd1, 6'd1, 2'd0});
        if (cnt == C_JOBS - 1)
          chk("t5_last_job", {cif.job_orow, cif.job_ocol, cif.job_filt, cif.job_irow, cif.job_icol},
              {6'd3, 6'd3, 2'd1, 6'd5, 6'd5});
        c_due[cif.job_lane] = (cnt == C_JOBS - 1) ? 6 : int'($urandom_range(1, 3));
        cnt++;
        if (cnt == 10) begin cif.en = 0; hold = 5; end
      end
      if (cif.done) begin done_at = cyc; alloc_at_done = cif.lane_alloc; end
      ld4 = '0;
      for (int l = 0; l < 4; l++)
        if (c_due[l] > 0) begin
          c_due[l]--;
          if (c_due[l] == 0) begin ld4[l] = 1'b1; last_ld = cyc; end
        end
      cif.lane_done = ld4;
    end
    chk("t5_job_count", cnt, C_JOBS);
    chk("t5_order", ord, 0);
    chk("t5_done_seen", done_at >= 0, 1);
    chk("t5_done_after_last", done_at > last_ld, 1);
    chk("t5_alloc_at_done", alloc_at_done, 0);
    @(posedge clk); #1;
    chk("t5_idle_after", {cif.busy, cif.done}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
